// File: rtl/sdp_ram_stream_reader.sv
// Stream reader for SDP RAM port B: turns (addr, len) commands into a valid/ready word stream.
// Optional stall counter output enabled by defining SDP_RAM_READER_STALL_CNT_EN.
module sdp_ram_stream_reader #(
    parameter int unsigned MEM_DATAWIDTH = 128,
    parameter int unsigned MEM_ADDRWIDTH = 14,
    parameter int unsigned LEN_WIDTH     = 14
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [MEM_ADDRWIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]     cmd_len,
    output logic                     mem_en,
    output logic [MEM_ADDRWIDTH-1:0] mem_addr,
    input  logic [MEM_DATAWIDTH-1:0] mem_rdata,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [MEM_DATAWIDTH-1:0] dout_data,
    output logic                     dout_last,
`ifdef SDP_RAM_READER_STALL_CNT_EN
    output logic [31:0]              stall_cnt,
`endif
    output logic                     busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e                   state_q;
    logic [LEN_WIDTH-1:0]     rem_q;
    logic                     mem_last_q;
    logic                     inflight_q;
    logic                     inflight_last_q;

    logic [MEM_DATAWIDTH-1:0] fifo_data_q [3];
    logic                     fifo_last_q [3];
    logic [1:0]               rd_ptr_q;
    logic [1:0]               wr_ptr_q;
    logic [1:0]               count_q;

    logic                     accept;
    logic                     push;
    logic                     pop;
    logic [1:0]               count_d;
    logic                     can_issue;

    always_comb begin
        cmd_ready  = (state_q == StIdle);
        busy       = (state_q != StIdle);
        accept     = cmd_valid && cmd_ready;
        dout_valid = (count_q != 2'd0);
        dout_data  = fifo_data_q[rd_ptr_q];
        dout_last  = fifo_last_q[rd_ptr_q];
        push       = inflight_q;
        pop        = dout_valid && dout_ready;
        count_d    = count_q + 2'(push) - 2'(pop);
        // Next cycle the current read becomes inflight; budget against next-cycle occupancy.
        can_issue  = (3'(count_d) + 3'(mem_en)) < 3'd3;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            rem_q           <= '0;
            mem_en          <= 1'b0;
            mem_addr        <= '0;
            mem_last_q      <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            rd_ptr_q        <= 2'd0;
            wr_ptr_q        <= 2'd0;
            count_q         <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            inflight_q      <= mem_en;
            inflight_last_q <= mem_last_q;
            count_q         <= count_d;

            if (push) begin
                fifo_data_q[wr_ptr_q] <= mem_rdata;
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q <= (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
            end

            // rem_q counts reads still to issue after the one currently on mem_addr.
            unique case (state_q)
                StIdle: begin
                    mem_en     <= 1'b0;
                    mem_last_q <= 1'b0;
                    if (accept) begin
                        mem_en     <= 1'b1;
                        mem_addr   <= cmd_addr;
                        mem_last_q <= (cmd_len == '0);
                        rem_q      <= cmd_len;
                        state_q    <= (cmd_len == '0) ? StDrain : StIssue;
                    end
                end
                StIssue: begin
                    if (can_issue) begin
                        mem_en     <= 1'b1;
                        mem_addr   <= mem_addr + 1'b1;
                        rem_q      <= rem_q - 1'b1;
                        mem_last_q <= (rem_q == LEN_WIDTH'(1));
                        if (rem_q == LEN_WIDTH'(1)) begin
                            state_q <= StDrain;
                        end
                    end else begin
                        mem_en     <= 1'b0;
                        mem_last_q <= 1'b0;
                    end
                end
                StDrain: begin
                    mem_en     <= 1'b0;
                    mem_last_q <= 1'b0;
                    if (pop && dout_last) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    mem_en  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SDP_RAM_READER_STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (accept) begin
            stall_cnt <= '0;
        end else if (dout_valid && !dout_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sdp_ram_stream_reader.sv
// Randomized self-checking bench for sdp_ram_stream_reader against a queue-based stream model.
`timescale 1ns/1ps
module tb_sdp_ram_stream_reader;
    localparam int DW = 128;
    localparam int AW = 14;
    localparam int LW = 14;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          dout_valid;
    logic          dout_ready = 1'b1;
    logic [DW-1:0] dout_data;
    logic          dout_last;
    logic          busy;
`ifdef SDP_RAM_READER_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    sdp_ram_stream_reader #(
        .MEM_DATAWIDTH(DW),
        .MEM_ADDRWIDTH(AW),
        .LEN_WIDTH    (LW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_data (dout_data),
        .dout_last (dout_last),
`ifdef SDP_RAM_READER_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int unsigned seed;

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        logic [31:0] h;
        h = ({18'h0, a} * 32'h9E37_79B1) ^ seed;
        return {h, ~h, h ^ 32'hA5A5_A5A5, {18'h0, a}};
    endfunction

    // RAM port B model: one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= word_of(mem_addr);
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected stream and expected issue addresses.
    logic [DW:0]   beat_q [$];
    logic [AW-1:0] addr_q [$];
    logic [DW:0]   exp_beat;
    logic [AW-1:0] a;
    int            issued = 0;
    int            popped = 0;
    int            accept_cyc = 0;
    bit            first_pending = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    int unsigned   stall_model = 0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (reset) begin
            check("rst_mem_en", DW'(mem_en), DW'(0));
            check("rst_mem_addr", DW'(mem_addr), DW'(0));
            check("rst_dout_valid", DW'(dout_valid), DW'(0));
            check("rst_dout_data", dout_data, DW'(0));
            check("rst_dout_last", DW'(dout_last), DW'(0));
            check("rst_busy", DW'(busy), DW'(0));
            check("rst_cmd_ready", DW'(cmd_ready), DW'(1));
`ifdef SDP_RAM_READER_STALL_CNT_EN
            check("rst_stall_cnt", DW'(stall_cnt), DW'(0));
`endif
            beat_q.delete();
            addr_q.delete();
            issued = 0;
            popped = 0;
            first_pending = 0;
            prev_stall = 0;
            stall_model = 0;
        end else begin
            check("cmd_ready", DW'(cmd_ready), DW'(beat_q.size() == 0));
            check("busy", DW'(busy), DW'(beat_q.size() != 0));
`ifdef SDP_RAM_READER_STALL_CNT_EN
            check("stall_cnt", DW'(stall_cnt), DW'(stall_model));
`endif
            if (cmd_valid && cmd_ready) begin
                for (int i = 0; i <= int'(cmd_len); i++) begin
                    a = cmd_addr + AW'(i);
                    addr_q.push_back(a);
                    beat_q.push_back({i == int'(cmd_len), word_of(a)});
                end
                accept_cyc = cyc;
                first_pending = 1;
                stall_model = 0;
            end
            if (mem_en) begin
                if (addr_q.size() == 0) check("spurious_issue", DW'(1), DW'(0));
                else check("mem_addr", DW'(mem_addr), DW'(addr_q.pop_front()));
                check("occupancy_lt3", DW'((issued - popped) < 3), DW'(1));
                issued++;
            end
            if (prev_stall) begin
                check("hold_valid", DW'(dout_valid), DW'(1));
                check("hold_data", dout_data, prev_data);
                check("hold_last", DW'(dout_last), DW'(prev_last));
            end
            if (dout_valid && first_pending) begin
                check("latency", DW'(cyc - accept_cyc), DW'(3));
                first_pending = 0;
            end
            if (dout_valid && dout_ready) begin
                if (beat_q.size() == 0) check("spurious_beat", DW'(1), DW'(0));
                else begin
                    exp_beat = beat_q.pop_front();
                    check("dout_data", dout_data, exp_beat[DW-1:0]);
                    check("dout_last", DW'(dout_last), DW'(exp_beat[DW]));
                end
                popped++;
            end
            prev_stall = dout_valid && !dout_ready;
            prev_data  = dout_data;
            prev_last  = dout_last;
            if (dout_valid && !dout_ready && stall_model != 32'hFFFF_FFFF) stall_model++;
        end
    end

    // Sink: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
    int         ready_mode = 0;
    int         ready_idx = 0;
    logic [3:0] ready_pat = 4'b1001;

    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0: dout_ready = 1'b1;
            1: begin
                dout_ready = ready_pat[ready_idx % 4];
                ready_idx++;
            end
            default: dout_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    task automatic send_cmd(input logic [AW-1:0] ad, input logic [LW-1:0] ln, input bit now);
        if (!now) begin
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b1;
        cmd_addr  = ad;
        cmd_len   = ln;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk);
                #1;
                cmd_valid = 1'b0;
                return;
            end
        end
        check("cmd_accept_timeout", DW'(0), DW'(1));
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (beat_q.size() == 0 && !cmd_valid) begin
                repeat (2) @(negedge clk);
                return;
            end
        end
        check("drain_timeout", DW'(beat_q.size()), DW'(0));
    endtask

    initial begin
        seed = $urandom;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        ready_mode = 0;
        send_cmd(14'h0010, 14'd0, 0);
        wait_idle();
        send_cmd(14'h0100, 14'd7, 0);
        wait_idle();
        ready_mode = 1;
        send_cmd(14'h0100, 14'd7, 0);
        wait_idle();
        ready_mode = 0;
        send_cmd(14'h3FFE, 14'd3, 0);
        wait_idle();
        // Second command held valid while the first is busy.
        send_cmd(14'h0200, 14'd5, 0);
        send_cmd(14'h0300, 14'd2, 1);
        wait_idle();

        // Asynchronous reset in the middle of a command.
        send_cmd(14'h0400, 14'd7, 0);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (popped >= 3) break;
        end
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(negedge clk);
        send_cmd(14'h0500, 14'd4, 0);
        wait_idle();

        for (int k = 0; k < 14; k++) begin
            ready_mode = (k % 3 == 0) ? 1 : 2;
            send_cmd(AW'($urandom), LW'($urandom_range(0, 20)), 0);
            wait_idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
